// File: rtl/nonce_result_writer.sv
// Result writer for the nonce-parallel SHA-256 miner: buffers one H0 per nonce, writes them out,
// then writes a hit/dup/timeout summary and the best H0. Optional collect timeout: NONCE_TIMEOUT_EN.
module nonce_result_writer #(
    parameter int unsigned NUM_NONCES     = 16,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] output_addr,
    input  logic [31:0]       target,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_nonce,
    input  logic [31:0]       in_h0,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_write_data,
    output logic              done,
    output logic              busy
);

    localparam int unsigned IDX_W = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;

    if (NUM_NONCES < 2 || NUM_NONCES > 16 || (NUM_NONCES & (NUM_NONCES - 1)) != 0
        || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("nonce_result_writer: unsupported NUM_NONCES or TIMEOUT_CYCLES");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_SUM0,
        S_SUM1,
        S_FIN
    } state_t;

    state_t                state;
    state_t                state_nx;

    logic [ADDR_W-1:0]     base;
    logic [31:0]           tgt;
    logic [31:0]           h0_buf [NUM_NONCES];
    logic [NUM_NONCES-1:0] seen;
    logic [NUM_NONCES-1:0] seen_upd;
    logic                  dup;
    logic                  tmo;
    logic [IDX_W-1:0]      idx;
    logic                  hit;
    logic [3:0]            best_nonce;
    logic [31:0]           best_h0;

    logic                  accept;
    logic                  nonce_ok;
    logic [IDX_W-1:0]      nidx;
    logic                  last_idx;
    logic                  timeout_hit;
    logic [31:0]           cur_word;
    logic                  cand;

    logic                  we_nx;
    logic                  done_nx;
    logic [ADDR_W-1:0]     addr_nx;
    logic [31:0]           data_nx;

    assign mem_clk  = clk;
    assign accept   = in_valid && in_ready;
    assign nonce_ok = 5'(in_nonce) < 5'(NUM_NONCES);
    assign nidx     = in_nonce[IDX_W-1:0];
    assign seen_upd = seen | ((accept && nonce_ok) ? (NUM_NONCES'(1'b1) << nidx) : '0);
    assign last_idx = (idx == IDX_W'(NUM_NONCES - 1));
    assign cur_word = seen[idx] ? h0_buf[idx] : 32'hFFFF_FFFF;
    assign cand     = seen[idx] && (h0_buf[idx] <= tgt);

`ifdef NONCE_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Idle-cycle counter; any accepted beat restarts the wait
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state != S_COLLECT || accept) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == S_COLLECT) && !accept && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Completion is judged on the mask including the current beat so in_ready drops right after it
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (start) state_nx = S_COLLECT;
            S_COLLECT: if ((&seen_upd) || timeout_hit) state_nx = S_WRITE;
            S_WRITE:   if (last_idx) state_nx = S_SUM0;
            S_SUM0:    state_nx = S_SUM1;
            S_SUM1:    state_nx = S_FIN;
            S_FIN:     state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        we_nx   = 1'b0;
        done_nx = 1'b0;
        addr_nx = mem_addr;
        data_nx = mem_write_data;
        case (state)
            S_WRITE: begin
                we_nx   = 1'b1;
                addr_nx = base + ADDR_W'(idx);
                data_nx = cur_word;
            end
            S_SUM0: begin
                we_nx   = 1'b1;
                addr_nx = base + ADDR_W'(NUM_NONCES);
                data_nx = {hit, dup, tmo, 25'b0, best_nonce};
            end
            S_SUM1: begin
                we_nx   = 1'b1;
                addr_nx = base + ADDR_W'(NUM_NONCES + 1);
                data_nx = hit ? best_h0 : 32'hFFFF_FFFF;
            end
            S_FIN:   done_nx = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready       <= 1'b0;
            busy           <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            done           <= 1'b0;
        end else begin
            in_ready       <= (state_nx == S_COLLECT);
            busy           <= (state_nx != S_IDLE);
            mem_we         <= we_nx;
            mem_addr       <= addr_nx;
            mem_write_data <= data_nx;
            done           <= done_nx;
        end
    end

    // Job bookkeeping; scan walks ascending so a strict compare keeps the lower nonce on ties
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base       <= '0;
            tgt        <= '0;
            seen       <= '0;
            dup        <= 1'b0;
            tmo        <= 1'b0;
            idx        <= '0;
            hit        <= 1'b0;
            best_nonce <= '0;
            best_h0    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base       <= output_addr;
                        tgt        <= target;
                        seen       <= '0;
                        dup        <= 1'b0;
                        tmo        <= 1'b0;
                        idx        <= '0;
                        hit        <= 1'b0;
                        best_nonce <= '0;
                        best_h0    <= '0;
                    end
                end
                S_COLLECT: begin
                    seen <= seen_upd;
                    if (accept && (!nonce_ok || seen[nidx])) dup <= 1'b1;
                    if (timeout_hit) tmo <= 1'b1;
                end
                S_WRITE: begin
                    idx <= idx + 1'b1;
                    if (cand && (!hit || h0_buf[idx] < best_h0)) begin
                        hit        <= 1'b1;
                        best_nonce <= 4'(idx);
                        best_h0    <= h0_buf[idx];
                    end
                end
                default: ;
            endcase
        end
    end

    // Hash buffer is plain storage; the seen mask qualifies every entry
    always_ff @(posedge clk) begin
        if (state == S_COLLECT && accept && nonce_ok) begin
            h0_buf[nidx] <= in_h0;
        end
    end

endmodule

// File: tb/tb_nonce_result_writer.sv
// Self-checking bench for nonce_result_writer: directed scenarios plus randomized jobs
// compared against a queue-based reference model.
module tb_nonce_result_writer;

    localparam int unsigned N  = 16;
    localparam int unsigned AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] output_addr;
    logic [31:0]   target;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_nonce;
    logic [31:0]   in_h0;
    logic          mem_clk;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_write_data;
    logic          done;
    logic          busy;

    nonce_result_writer #(.NUM_NONCES(N), .ADDR_W(AW), .TIMEOUT_CYCLES(1024)) dut (
        .clk(clk), .reset(reset), .start(start), .output_addr(output_addr), .target(target),
        .in_valid(in_valid), .in_ready(in_ready), .in_nonce(in_nonce), .in_h0(in_h0),
        .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            q_n[$];
    logic [31:0]   q_h[$];
    int            q_gap[$];
    logic [AW-1:0] cap_a[$];
    logic [31:0]   cap_d[$];
    int            cap_c[$];
    logic [AW-1:0] exp_a[$];
    logic [31:0]   exp_d[$];
    int            done_c;
    int            rdy_bad;
    logic          rdy_after;
    logic          done_after;
    logic          busy_after;

    // Reference: last write per nonce wins, best = minimum qualifying value, lowest nonce among equals
    task automatic build_model(input logic [AW-1:0] base, input logic [31:0] tgt, input bit timed_out);
        logic [31:0] h [N];
        bit          s [N];
        bit          dup;
        bit          hit;
        logic [31:0] lo;
        int          bn;
        dup = 1'b0; hit = 1'b0; lo = 32'hFFFF_FFFF; bn = 0;
        for (int i = 0; i < N; i++) begin s[i] = 1'b0; h[i] = '0; end
        for (int k = 0; k < q_n.size(); k++) begin
            if (s[q_n[k]]) dup = 1'b1;
            s[q_n[k]] = 1'b1;
            h[q_n[k]] = q_h[k];
        end
        for (int i = 0; i < N; i++) begin
            if (s[i] && h[i] <= tgt) begin
                hit = 1'b1;
                if (h[i] < lo) lo = h[i];
            end
        end
        if (hit) for (int i = N - 1; i >= 0; i--) if (s[i] && h[i] == lo) bn = i;
        exp_a.delete(); exp_d.delete();
        for (int i = 0; i < N; i++) begin
            exp_a.push_back(base + AW'(i));
            exp_d.push_back(s[i] ? h[i] : 32'hFFFF_FFFF);
        end
        exp_a.push_back(base + AW'(N));
        exp_d.push_back({hit, dup, timed_out, 25'b0, 4'(bn)});
        exp_a.push_back(base + AW'(N + 1));
        exp_d.push_back(hit ? lo : 32'hFFFF_FFFF);
    endtask

    task automatic start_job(input logic [AW-1:0] base, input logic [31:0] tgt);
        @(negedge clk);
        output_addr = base; target = tgt; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beats();
        rdy_bad = 0;
        for (int k = 0; k < q_n.size(); k++) begin
            repeat (q_gap[k]) @(negedge clk);
            if (in_ready !== 1'b1) rdy_bad++;
            in_valid = 1'b1; in_nonce = 4'(q_n[k]); in_h0 = q_h[k];
            @(negedge clk);
            in_valid = 1'b0; in_nonce = 4'($urandom); in_h0 = $urandom;
        end
        rdy_after = in_ready;
    endtask

    // Cycle 0 is the negedge right after the last beat; captures every write until done
    task automatic run_job(input logic [AW-1:0] base, input logic [31:0] tgt, input int budget);
        start_job(base, tgt);
        send_beats();
        cap_a.delete(); cap_d.delete(); cap_c.delete();
        done_c = -1;
        for (int c = 0; c < budget; c++) begin
            if (mem_we === 1'b1) begin
                cap_a.push_back(mem_addr); cap_d.push_back(mem_write_data); cap_c.push_back(c);
            end
            if (done === 1'b1) begin done_c = c; break; end
            @(negedge clk);
        end
        @(negedge clk);
        done_after = done; busy_after = busy;
    endtask

    function automatic logic [31:0] rnd_h(input logic [31:0] prev);
        case ($urandom_range(3, 0))
            0:       return $urandom;
            1:       return $urandom >> $urandom_range(31, 0);
            2:       return prev;
            default: return $urandom & 32'h0000_FFFF;
        endcase
    endfunction

    task automatic clear_beats();
        q_n.delete(); q_h.delete(); q_gap.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_nonce = '0; in_h0 = '0;
        output_addr = '0; target = '0;
        repeat (3) @(negedge clk);
        n_assert++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_assert++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_assert++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_assert++; if (mem_write_data !== '0) begin n_fail++; $display("FAIL reset_mem_data: got %h want 0", mem_write_data); end
        n_assert++; if (mem_clk !== clk) begin n_fail++; $display("FAIL mem_clk: got %b want %b", mem_clk, clk); end
        reset = 1'b0;
        @(negedge clk);
        n_assert++; if (in_ready !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_outputs: got rdy=%b busy=%b want 0 0", in_ready, busy);
        end
    endtask

    task automatic test_in_order();
        clear_beats();
        for (int n = 0; n < N; n++) begin q_n.push_back(n); q_h.push_back(32'h1000_0000 + 32'(n)); q_gap.push_back(0); end
        build_model(16'h0100, 32'h0000_FFFF, 1'b0);
        run_job(16'h0100, 32'h0000_FFFF, 100);
        n_assert++; if (cap_a.size() != N + 2) begin n_fail++; $display("FAIL order_nwrites: got %0d want %0d", cap_a.size(), N + 2); end
        for (int j = 0; j < N + 2 && j < cap_a.size(); j++) begin
            n_assert++;
            if (cap_a[j] !== exp_a[j] || cap_d[j] !== exp_d[j] || cap_c[j] !== j + 1) begin
                n_fail++; $display("FAIL order_wr%0d: got %h=%h @%0d want %h=%h @%0d", j, cap_a[j], cap_d[j], cap_c[j], exp_a[j], exp_d[j], j + 1);
            end
        end
        if (cap_a.size() == N + 2) begin
            n_assert++; if (cap_a[N] !== 16'h0110 || cap_d[N] !== 32'h0000_0000) begin
                n_fail++; $display("FAIL order_summary: got %h=%h want 0110=00000000", cap_a[N], cap_d[N]);
            end
            n_assert++; if (cap_a[N + 1] !== 16'h0111 || cap_d[N + 1] !== 32'hFFFF_FFFF) begin
                n_fail++; $display("FAIL order_best: got %h=%h want 0111=ffffffff", cap_a[N + 1], cap_d[N + 1]);
            end
        end
        n_assert++; if (done_c !== N + 3) begin n_fail++; $display("FAIL order_done_cycle: got %0d want %0d", done_c, N + 3); end
        n_assert++; if (done_after !== 1'b0 || busy_after !== 1'b0) begin
            n_fail++; $display("FAIL order_done_pulse: got done=%b busy=%b want 0 0", done_after, busy_after);
        end
        n_assert++; if (rdy_bad !== 0 || rdy_after !== 1'b0) begin
            n_fail++; $display("FAIL order_ready: got bad=%0d after=%b want 0 0", rdy_bad, rdy_after);
        end
    endtask

    task automatic test_tie();
        clear_beats();
        for (int n = 0; n < N; n++) begin
            q_n.push_back(n);
            q_h.push_back((n == 3 || n == 9) ? 32'h0000_0050 : 32'h1000_0000 + 32'(n));
            q_gap.push_back(0);
        end
        build_model(16'h0100, 32'h0000_1000, 1'b0);
        run_job(16'h0100, 32'h0000_1000, 100);
        for (int j = 0; j < N + 2 && j < cap_a.size(); j++) begin
            n_assert++;
            if (cap_a[j] !== exp_a[j] || cap_d[j] !== exp_d[j]) begin
                n_fail++; $display("FAIL tie_wr%0d: got %h=%h want %h=%h", j, cap_a[j], cap_d[j], exp_a[j], exp_d[j]);
            end
        end
        n_assert++; if (cap_d.size() != N + 2) begin n_fail++; $display("FAIL tie_nwrites: got %0d want %0d", cap_d.size(), N + 2); end
        else begin
            n_assert++; if (cap_d[N] !== 32'h8000_0003) begin n_fail++; $display("FAIL tie_summary: got %h want 80000003", cap_d[N]); end
            n_assert++; if (cap_d[N + 1] !== 32'h0000_0050) begin n_fail++; $display("FAIL tie_best: got %h want 00000050", cap_d[N + 1]); end
        end
    endtask

    task automatic test_reverse_gaps();
        clear_beats();
        for (int n = N - 1; n >= 0; n--) begin q_n.push_back(n); q_h.push_back($urandom); q_gap.push_back($urandom_range(3, 0)); end
        build_model(16'h0200, $urandom, 1'b0);
        run_job(16'h0200, target, 100);
        build_model(16'h0200, target, 1'b0);
        n_assert++; if (cap_a.size() != N + 2) begin n_fail++; $display("FAIL rev_nwrites: got %0d want %0d", cap_a.size(), N + 2); end
        for (int j = 0; j < N + 2 && j < cap_a.size(); j++) begin
            n_assert++;
            if (cap_a[j] !== exp_a[j] || cap_d[j] !== exp_d[j]) begin
                n_fail++; $display("FAIL rev_wr%0d: got %h=%h want %h=%h", j, cap_a[j], cap_d[j], exp_a[j], exp_d[j]);
            end
        end
        n_assert++; if (rdy_bad !== 0 || rdy_after !== 1'b0) begin
            n_fail++; $display("FAIL rev_ready: got bad=%0d after=%b want 0 0", rdy_bad, rdy_after);
        end
    endtask

    task automatic test_dup();
        clear_beats();
        for (int n = 0; n < N; n++) begin
            if (n == N - 1) begin q_n.push_back(5); q_h.push_back(32'hAAAA_AAAA); q_gap.push_back(1); end
            q_n.push_back(n); q_h.push_back(32'h2000_0000 + 32'(n)); q_gap.push_back(0);
        end
        build_model(16'h0100, 32'hFFFF_FFFF, 1'b0);
        run_job(16'h0100, 32'hFFFF_FFFF, 100);
        n_assert++; if (cap_a.size() != N + 2) begin n_fail++; $display("FAIL dup_nwrites: got %0d want %0d", cap_a.size(), N + 2); end
        else begin
            n_assert++; if (cap_a[5] !== 16'h0105 || cap_d[5] !== 32'hAAAA_AAAA) begin
                n_fail++; $display("FAIL dup_entry5: got %h=%h want 0105=aaaaaaaa", cap_a[5], cap_d[5]);
            end
            n_assert++; if (cap_d[N][30] !== 1'b1) begin n_fail++; $display("FAIL dup_bit30: got %b want 1", cap_d[N][30]); end
        end
        for (int j = 0; j < N + 2 && j < cap_a.size(); j++) begin
            n_assert++;
            if (cap_a[j] !== exp_a[j] || cap_d[j] !== exp_d[j]) begin
                n_fail++; $display("FAIL dup_wr%0d: got %h=%h want %h=%h", j, cap_a[j], cap_d[j], exp_a[j], exp_d[j]);
            end
        end
        n_assert++; if (rdy_bad !== 0 || rdy_after !== 1'b0) begin
            n_fail++; $display("FAIL dup_ready: got bad=%0d after=%b want 0 0", rdy_bad, rdy_after);
        end
    endtask

    task automatic test_wrap();
        clear_beats();
        for (int n = 0; n < N; n++) begin q_n.push_back(n); q_h.push_back($urandom); q_gap.push_back(0); end
        build_model(16'hFFF8, 32'h8000_0000, 1'b0);
        run_job(16'hFFF8, 32'h8000_0000, 100);
        n_assert++; if (cap_a.size() != N + 2) begin n_fail++; $display("FAIL wrap_nwrites: got %0d want %0d", cap_a.size(), N + 2); end
        else begin
            n_assert++; if (cap_a[8] !== 16'h0000) begin n_fail++; $display("FAIL wrap_nonce8: got %h want 0000", cap_a[8]); end
            n_assert++; if (cap_a[N] !== 16'h0008) begin n_fail++; $display("FAIL wrap_summary: got %h want 0008", cap_a[N]); end
        end
        for (int j = 0; j < N + 2 && j < cap_a.size(); j++) begin
            n_assert++;
            if (cap_a[j] !== exp_a[j] || cap_d[j] !== exp_d[j]) begin
                n_fail++; $display("FAIL wrap_wr%0d: got %h=%h want %h=%h", j, cap_a[j], cap_d[j], exp_a[j], exp_d[j]);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        bit found;
        int stray;
        clear_beats();
        for (int n = 0; n < N; n++) begin q_n.push_back(n); q_h.push_back($urandom); q_gap.push_back(0); end
        start_job(16'h0100, 32'hFFFF_FFFF);
        send_beats();
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (mem_we === 1'b1 && mem_addr === 16'h0107) found = 1'b1;
            else @(negedge clk);
        end
        n_assert++; if (!found) begin n_fail++; $display("FAIL rst_reach_i7: got 0 want 1"); end
        reset = 1'b1;
        #1;
        n_assert++; if (mem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL rst_abort: got we=%b busy=%b rdy=%b done=%b want 0 0 0 0", mem_we, busy, in_ready, done);
        end
        @(negedge clk);
        reset = 1'b0;
        stray = 0;
        repeat (30) begin
            @(negedge clk);
            if (mem_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) stray++;
        end
        n_assert++; if (stray !== 0) begin n_fail++; $display("FAIL rst_quiet: got %0d active cycles want 0", stray); end
        clear_beats();
        for (int n = 0; n < N; n++) begin q_n.push_back(n); q_h.push_back($urandom >> 4); q_gap.push_back(0); end
        build_model(16'h0300, 32'h0800_0000, 1'b0);
        run_job(16'h0300, 32'h0800_0000, 100);
        n_assert++; if (cap_a.size() != N + 2) begin n_fail++; $display("FAIL rst_rerun_nwrites: got %0d want %0d", cap_a.size(), N + 2); end
        for (int j = 0; j < N + 2 && j < cap_a.size(); j++) begin
            n_assert++;
            if (cap_a[j] !== exp_a[j] || cap_d[j] !== exp_d[j]) begin
                n_fail++; $display("FAIL rst_rerun_wr%0d: got %h=%h want %h=%h", j, cap_a[j], cap_d[j], exp_a[j], exp_d[j]);
            end
        end
    endtask

    task automatic test_random();
        int          order [N];
        int          j;
        int          t;
        logic [31:0] prev;
        logic [31:0] tgt;
        logic [AW-1:0] base;
        for (int iter = 0; iter < 6; iter++) begin
            clear_beats();
            for (int i = 0; i < N; i++) order[i] = i;
            for (int i = N - 1; i > 0; i--) begin
                j = int'($urandom_range(i, 0)); t = order[i]; order[i] = order[j]; order[j] = t;
            end
            prev = $urandom;
            for (int k = 0; k < N; k++) begin
                if (k > 0 && $urandom_range(3, 0) == 0) begin
                    q_n.push_back(order[$urandom_range(k - 1, 0)]); prev = rnd_h(prev);
                    q_h.push_back(prev); q_gap.push_back($urandom_range(2, 0));
                end
                q_n.push_back(order[k]); prev = rnd_h(prev);
                q_h.push_back(prev); q_gap.push_back($urandom_range(2, 0));
            end
            tgt  = $urandom >> $urandom_range(24, 0);
            base = AW'($urandom);
            build_model(base, tgt, 1'b0);
            run_job(base, tgt, 100);
            n_assert++; if (cap_a.size() != N + 2) begin n_fail++; $display("FAIL rnd%0d_nwrites: got %0d want %0d", iter, cap_a.size(), N + 2); end
            for (int m = 0; m < N + 2 && m < cap_a.size(); m++) begin
                n_assert++;
                if (cap_a[m] !== exp_a[m] || cap_d[m] !== exp_d[m]) begin
                    n_fail++; $display("FAIL rnd%0d_wr%0d: got %h=%h want %h=%h", iter, m, cap_a[m], cap_d[m], exp_a[m], exp_d[m]);
                end
            end
            n_assert++; if (done_c !== N + 3 || rdy_bad !== 0) begin
                n_fail++; $display("FAIL rnd%0d_timing: got done@%0d bad=%0d want done@%0d bad=0", iter, done_c, rdy_bad, N + 3);
            end
        end
    endtask

`ifdef NONCE_TIMEOUT_EN
    task automatic test_timeout();
        clear_beats();
        for (int n = 0; n < N - 1; n++) begin q_n.push_back(n); q_h.push_back($urandom); q_gap.push_back(0); end
        build_model(16'h0100, 32'hFFFF_FFFF, 1'b1);
        run_job(16'h0100, 32'hFFFF_FFFF, 3000);
        n_assert++; if (cap_a.size() != N + 2) begin n_fail++; $display("FAIL tmo_nwrites: got %0d want %0d", cap_a.size(), N + 2); end
        else begin
            n_assert++; if (cap_a[N - 1] !== 16'h010F || cap_d[N - 1] !== 32'hFFFF_FFFF) begin
                n_fail++; $display("FAIL tmo_entry15: got %h=%h want 010f=ffffffff", cap_a[N - 1], cap_d[N - 1]);
            end
            n_assert++; if (cap_d[N][29] !== 1'b1) begin n_fail++; $display("FAIL tmo_bit29: got %b want 1", cap_d[N][29]); end
            n_assert++; if (cap_c[0] < 1000 || cap_c[0] > 1030) begin
                n_fail++; $display("FAIL tmo_wait: got %0d cycles want about 1024", cap_c[0]);
            end
        end
        for (int j = 0; j < N + 2 && j < cap_a.size(); j++) begin
            n_assert++;
            if (cap_a[j] !== exp_a[j] || cap_d[j] !== exp_d[j]) begin
                n_fail++; $display("FAIL tmo_wr%0d: got %h=%h want %h=%h", j, cap_a[j], cap_d[j], exp_a[j], exp_d[j]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_in_order();
        test_tie();
        test_reverse_gaps();
        test_dup();
        test_wrap();
        test_reset_mid_write();
        test_random();
`ifdef NONCE_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
